// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end (window generator, conv_2d).
package conv_pkg;

    // Default pixel width in bits.
    localparam int W_DEFAULT = 8;

    // Width of a row/column coordinate for an n-pixel dimension (at least 1 bit).
    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of window element (r, c) inside a flattened m x m window of w-bit pixels.
    function automatic int win_off(input int r, input int c, input int m, input int w);
        return (r * m + c) * w;
    endfunction

endpackage

// File: rtl/conv_line_shift.sv
// W-bit shift register of depth D with shift enable and synchronous active-low clear.
// Entry 0 is the newest value; every entry is exposed on taps.
module conv_line_shift #(
    parameter int W = 8,
    parameter int D = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [W-1:0]     din,
    output logic [D*W-1:0]   taps
);

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_stage
            logic [W-1:0] stage_q;
            logic [W-1:0] stage_d;
            logic [W-1:0] prev;

            if (gi == 0) begin : g_head
                assign prev = din;
            end else begin : g_body
                assign prev = taps[(gi-1)*W +: W];
            end

            // Take the upstream value when shifting, otherwise hold.
            always_comb begin
                stage_d = stage_q;
                if (shift_en) begin
                    stage_d = prev;
                end
            end

            // Stage register, cleared while reset is asserted.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign taps[gi*W +: W] = stage_q;
        end
    endgenerate

endmodule

// File: rtl/conv_window_gen.sv
// Converts a raster-order pixel stream of an N x N frame into valid-position
// M x M sliding windows, one flattened window per valid/ready handshake.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int N = 5,
    parameter int M = 3,
    parameter int W = W_DEFAULT,
    localparam int CW = cw_of(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [W-1:0]       in_pixel,
    output logic               in_ready,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [M*M*W-1:0]   win_data,
    output logic [CW-1:0]      win_row,
    output logic [CW-1:0]      win_col,
    output logic               frame_done
);

    localparam int D = (M - 1) * N + M;

    generate
        if (M < 1 || M > N) begin : g_param_check
            $error("conv_window_gen: M must satisfy 1 <= M <= N");
        end
    endgenerate

    logic [CW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic               win_valid_q, win_valid_d;
    logic [M*M*W-1:0]   win_data_q, win_data_d;
    logic [CW-1:0]      win_row_q, win_row_d;
    logic [CW-1:0]      win_col_q, win_col_d;
    logic               frame_done_q, frame_done_d;

    logic               accept;
    logic               emit;
    logic               handshake;
    logic [D*W-1:0]     line_taps;
    logic [D*W-1:0]     view;
    logic [M*M*W-1:0]   win_next;
    logic               unused_oldest;

    assign in_ready  = rst && (!win_valid_q || win_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = win_valid_q && win_ready;
    assign emit      = accept && (int'(row_q) >= M - 1) && (int'(col_q) >= M - 1);

    conv_line_shift #(
        .W (W),
        .D (D)
    ) u_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (in_pixel),
        .taps     (line_taps)
    );

    // Newest-first view as it will be after this accept: the incoming pixel is
    // tapped directly, so the oldest stored entry never reaches a window.
    genvar gi, gj;
    generate
        if (D == 1) begin : g_view_single
            assign view = in_pixel;
        end else begin : g_view_multi
            assign view = {line_taps[(D-1)*W-1:0], in_pixel};
        end
        assign unused_oldest = ^line_taps[D*W-1 -: W];

        for (gi = 0; gi < M; gi++) begin : g_win_r
            for (gj = 0; gj < M; gj++) begin : g_win_c
                assign win_next[win_off(gi, gj, M, W) +: W] =
                    view[((M - 1 - gi) * N + (M - 1 - gj)) * W +: W];
            end
        end
    endgenerate

    // Raster counters, one-deep output register and end-of-frame pulse.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        win_data_d   = win_data_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (accept) begin
            if (int'(col_q) == N - 1) begin
                col_d = '0;
                row_d = (int'(row_q) == N - 1) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (emit) begin
            win_valid_d = 1'b1;
            win_data_d  = win_next;
            win_row_d   = CW'(int'(row_q) - (M - 1));
            win_col_d   = CW'(int'(col_q) - (M - 1));
        end else if (handshake) begin
            win_valid_d = 1'b0;
        end

        if (handshake && int'(win_row_q) == N - M && int'(win_col_q) == N - M) begin
            frame_done_d = 1'b1;
        end
    end

    // State registers; reset discards any partial frame and pending window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: scoreboard of expected windows,
// table of frame scenarios, hand sequences for stall/reset, and two edge configs.
module tb_conv_window_gen;

    localparam int N  = 5;
    localparam int M  = 3;
    localparam int W  = 8;
    localparam int CW = 3;
    localparam int DW = M * M * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_pixel;
    logic           in_ready;
    logic           win_valid;
    logic           win_ready;
    logic [DW-1:0]  win_data;
    logic [CW-1:0]  win_row;
    logic [CW-1:0]  win_col;
    logic           frame_done;

    conv_window_gen #(.N(N), .M(M), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done)
    );

    // Edge configuration A: N=4, M=1.
    logic a_in_valid, a_in_ready, a_win_valid, a_win_ready, a_frame_done;
    logic [7:0] a_in_pixel, a_win_data;
    logic [1:0] a_win_row, a_win_col;
    conv_window_gen #(.N(4), .M(1), .W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_pixel(a_in_pixel),
        .in_ready(a_in_ready), .win_valid(a_win_valid), .win_ready(a_win_ready),
        .win_data(a_win_data), .win_row(a_win_row), .win_col(a_win_col),
        .frame_done(a_frame_done)
    );

    // Edge configuration B: N=M=3.
    logic b_in_valid, b_in_ready, b_win_valid, b_win_ready, b_frame_done;
    logic [7:0]  b_in_pixel;
    logic [71:0] b_win_data;
    logic [1:0]  b_win_row, b_win_col;
    conv_window_gen #(.N(3), .M(3), .W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_pixel(b_in_pixel),
        .in_ready(b_in_ready), .win_valid(b_win_valid), .win_ready(b_win_ready),
        .win_data(b_win_data), .win_row(b_win_row), .win_col(b_win_col),
        .frame_done(b_frame_done)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } win_t;

    win_t       exp_q[$];
    logic [7:0] pix_mem [N*N];
    int         mr = 0;
    int         mc = 0;
    bit         mon_en   = 1'b0;
    bit         exp_done = 1'b0;
    int         hs_count   = 0;
    int         done_count = 0;

    int a_seen = 0, a_done = 0, b_seen = 0, b_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mkwin(input int p0, input int p1, input int p2,
                                             input int p3, input int p4, input int p5,
                                             input int p6, input int p7, input int p8);
        return {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0],
                p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endfunction

    // Reference model: record the accepted pixel and queue the window it completes.
    task automatic model_accept(input logic [7:0] px);
        win_t e;
        pix_mem[mr*N + mc] = px;
        if (mr >= M-1 && mc >= M-1) begin
            e.row  = CW'(mr - (M-1));
            e.col  = CW'(mc - (M-1));
            e.data = '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++)
                    e.data[(i*M + j)*W +: W] = pix_mem[(mr-M+1+i)*N + (mc-M+1+j)];
            exp_q.push_back(e);
        end
        if (mc == N-1) begin
            mc = 0;
            mr = (mr == N-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    // Scoreboard: compare every handshaken window and the frame_done pulse.
    always @(negedge clk) begin : monitor
        win_t e;
        if (mon_en) begin
            check("frame_done", frame_done, exp_done);
            if (frame_done) done_count++;
            exp_done = 1'b0;
            if (win_valid && win_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window_queue_depth", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("win_data", win_data, e.data);
                    check("win_row", win_row, e.row);
                    check("win_col", win_col, e.col);
                    $display("window row=%0d col=%0d data=%0h", win_row, win_col, win_data);
                    if (int'(e.row) == N-M && int'(e.col) == N-M) exp_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor_a
        if (a_win_valid && a_win_ready) begin
            check("a_win_data", a_win_data, a_seen + 1);
            check("a_win_row", a_win_row, a_seen / 4);
            check("a_win_col", a_win_col, a_seen % 4);
            a_seen++;
        end
        if (a_frame_done) a_done++;
    end

    always @(negedge clk) begin : monitor_b
        if (b_win_valid && b_win_ready) begin
            check("b_win_data", b_win_data, mkwin(1, 2, 3, 4, 5, 6, 7, 8, 9));
            check("b_win_pos", {b_win_row, b_win_col}, 0);
            b_seen++;
        end
        if (b_frame_done) b_done++;
    end

    // Offer one pixel until accepted (bounded); optionally randomise win_ready.
    task automatic send_pixel(input logic [7:0] px, input bit rnd);
        int waited = 0;
        in_valid = 1'b1;
        in_pixel = px;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd) win_ready = ($urandom_range(0, 3) != 0);
        end
        model_accept(px);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) win_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        win_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input int base, input bit gap, input bit rnd);
        for (int i = 0; i < N*N; i++) begin
            send_pixel(8'(base + i), rnd);
            if (gap) idle(1);
        end
    endtask

    typedef struct {
        int base;
        int frames;
        bit gap;
        bit rnd;
        int exp_win;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int h0, d0;
        vecs[0] = '{base: 1,  frames: 1, gap: 1'b0, rnd: 1'b0, exp_win: 9,  exp_done: 1};
        vecs[1] = '{base: 1,  frames: 1, gap: 1'b1, rnd: 1'b0, exp_win: 9,  exp_done: 1};
        vecs[2] = '{base: 1,  frames: 2, gap: 1'b0, rnd: 1'b0, exp_win: 18, exp_done: 2};
        vecs[3] = '{base: 50, frames: 1, gap: 1'b1, rnd: 1'b1, exp_win: 9,  exp_done: 1};

        rst = 1'b0; in_valid = 1'b0; in_pixel = '0; win_ready = 1'b1;
        a_in_valid = 1'b0; a_in_pixel = '0; a_win_ready = 1'b1;
        b_in_valid = 1'b0; b_in_pixel = '0; b_win_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_win_valid", win_valid, 0);
        check("reset_win_data", win_data, 0);
        check("reset_win_pos", {win_row, win_col}, 0);
        check("reset_frame_done", frame_done, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Streaming with a backpressure stall after the first window.
        h0 = hs_count; d0 = done_count;
        for (int i = 1; i <= 12; i++) send_pixel(8'(i), 1'b0);
        @(negedge clk);
        check("no_window_before_13", win_valid, 0);
        @(posedge clk); #1;
        send_pixel(8'd13, 1'b0);
        win_ready = 1'b0;
        @(negedge clk);
        check("first_window_latency", win_valid, 1);
        check("first_window_data", win_data, mkwin(1, 2, 3, 6, 7, 8, 11, 12, 13));
        check("first_window_pos", {win_row, win_col}, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_pixel = 8'd14;
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_win_data", win_data, mkwin(1, 2, 3, 6, 7, 8, 11, 12, 13));
            @(posedge clk); #1;
        end
        win_ready = 1'b1;
        send_pixel(8'd14, 1'b0);
        @(negedge clk);
        check("after_stall_data", win_data, mkwin(2, 3, 4, 7, 8, 9, 12, 13, 14));
        check("after_stall_pos", {win_row, win_col}, {3'd0, 3'd1});
        @(posedge clk); #1;
        for (int i = 15; i <= 24; i++) send_pixel(8'(i), 1'b0);
        send_pixel(8'd25, 1'b0);
        @(negedge clk);
        check("last_window_data", win_data, mkwin(13, 14, 15, 18, 19, 20, 23, 24, 25));
        check("last_window_pos", {win_row, win_col}, {3'd2, 3'd2});
        @(posedge clk); #1;
        drain();
        check("stream_windows", hs_count - h0, 9);
        check("stream_frame_done", done_count - d0, 1);

        // Table of frame scenarios.
        for (int v = 0; v < 4; v++) begin
            h0 = hs_count; d0 = done_count;
            for (int f = 0; f < vecs[v].frames; f++)
                run_frame(vecs[v].base + 100*f, vecs[v].gap, vecs[v].rnd);
            drain();
            check($sformatf("vec%0d_windows", v), hs_count - h0, vecs[v].exp_win);
            check($sformatf("vec%0d_frame_done", v), done_count - d0, vecs[v].exp_done);
        end

        // Mid-frame reset with a pending window.
        win_ready = 1'b1;
        for (int i = 1; i <= 17; i++) send_pixel(8'(i), 1'b0);
        win_ready = 1'b0;
        send_pixel(8'd18, 1'b0);
        @(negedge clk);
        check("pending_before_reset", win_valid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        mr = 0; mc = 0;
        @(negedge clk);
        check("mid_reset_win_valid", win_valid, 0);
        check("mid_reset_win_data", win_data, 0);
        @(posedge clk); #1;
        win_ready = 1'b1;
        h0 = hs_count; d0 = done_count;
        run_frame(1, 1'b0, 1'b0);
        drain();
        check("after_reset_windows", hs_count - h0, 9);
        check("after_reset_frame_done", done_count - d0, 1);

        // Edge configurations.
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1;
            a_in_pixel = 8'(i + 1);
            @(negedge clk);
            if (i == 0) check("a_in_ready", a_in_ready, 1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_in_valid = 1'b1;
            b_in_pixel = 8'(i + 1);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("a_window_count", a_seen, 16);
        check("a_frame_done_count", a_done, 1);
        check("b_window_count", b_seen, 1);
        check("b_frame_done_count", b_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
